// File: rtl/controlador_de_funcionalidade.sv
// Round-robin sequencer for the shared S output of multiplexadorDeFuncionalidade.
// Grants A or B with minimum hold / maximum grant, operator force via MODO, and a P=00 gap between selections.
module controlador_de_funcionalidade #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_GRANT   = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] MODO,
  input  logic       REQ_A,
  input  logic       REQ_B,
  output logic [1:0] P,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT_A = 3'd1,
    ST_GRANT_B = 3'd2,
    ST_FORCE   = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GRANT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic             LAST_A    = 1'b0;
  localparam logic             LAST_B    = 1'b1;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic             last_r, last_s;
  logic [1:0]       mode_r, mode_s;
  logic [1:0]       p_s;
  logic             force_req_s;
  logic             hold_done_s;
  logic             max_done_s;

  // Next-state, grant bookkeeping and next select value
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_s      = last_r;
    mode_s      = mode_r;
    p_s         = 2'b00;
    force_req_s = (MODO != 2'b00);
    hold_done_s = (cnt_r >= HOLD_LAST);
    max_done_s  = (cnt_r >= MAX_LAST);
    if (cnt_r == CNT_SAT) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_r)
      ST_IDLE, ST_GAP: begin
        // Tie goes to the side that did not hold the last grant
        if (force_req_s) begin
          state_s = ST_FORCE;
          mode_s  = MODO;
        end else if (REQ_A && (!REQ_B || (last_r == LAST_B))) begin
          state_s = ST_GRANT_A;
          cnt_s   = {CNT_W{1'b0}};
          last_s  = LAST_A;
        end else if (REQ_B) begin
          state_s = ST_GRANT_B;
          cnt_s   = {CNT_W{1'b0}};
          last_s  = LAST_B;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT_A: begin
        if (force_req_s || (hold_done_s && !REQ_A) || (max_done_s && REQ_B)) begin
          state_s = ST_GAP;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_GRANT_B: begin
        if (force_req_s || (hold_done_s && !REQ_B) || (max_done_s && REQ_A)) begin
          state_s = ST_GAP;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_FORCE: begin
        if (MODO != mode_r) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_FORCE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    case (state_s)
      ST_GRANT_A: p_s = 2'b10;
      ST_GRANT_B: p_s = 2'b01;
      ST_FORCE:   p_s = mode_s;
      default:    p_s = 2'b00;
    endcase
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      last_r  <= LAST_B;
      mode_r  <= 2'b00;
      P       <= 2'b00;
      GNT_A   <= 1'b0;
      GNT_B   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      mode_r  <= mode_s;
      P       <= p_s;
      GNT_A   <= p_s[1];
      GNT_B   <= p_s[0];
      BUSY    <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_controlador_de_funcionalidade.sv
// Directed-vector bench for controlador_de_funcionalidade (HOLD_CYCLES=4, MAX_GRANT=8).
module tb_controlador_de_funcionalidade;

  logic       clock;
  logic       reset;
  logic [1:0] MODO;
  logic       REQ_A;
  logic       REQ_B;
  logic [1:0] P;
  logic       GNT_A;
  logic       GNT_B;
  logic       BUSY;

  int vec_cnt;
  int err_cnt;

  controlador_de_funcionalidade #(
    .HOLD_CYCLES(4),
    .MAX_GRANT  (8),
    .CNT_W      (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .MODO (MODO),
    .REQ_A(REQ_A),
    .REQ_B(REQ_B),
    .P    (P),
    .GNT_A(GNT_A),
    .GNT_B(GNT_B),
    .BUSY (BUSY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare every output against the expected select and busy
  task automatic step(input string tag, input logic [1:0] exp_p, input logic exp_busy);
    @(posedge clock);
    #1;
    check_val({tag, ".P"},     {30'd0, P},     {30'd0, exp_p});
    check_val({tag, ".GNT_A"}, {31'd0, GNT_A}, {31'd0, exp_p[1]});
    check_val({tag, ".GNT_B"}, {31'd0, GNT_B}, {31'd0, exp_p[0]});
    check_val({tag, ".BUSY"},  {31'd0, BUSY},  {31'd0, exp_busy});
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b1;
    MODO    = 2'b00;
    REQ_A   = 1'b1;
    REQ_B   = 1'b0;

    // Reset held with A requesting, then A granted on first edge after release
    step("rst0", 2'b00, 1'b0);
    step("rst1", 2'b00, 1'b0);
    reset = 1'b0;
    step("rel_a", 2'b10, 1'b1);

    // Long uncontended A grant: no gap, counter saturates silently
    for (int i = 0; i < 19; i++) step("long_a", 2'b10, 1'b1);
    REQ_A = 1'b0;
    step("long_a_gap", 2'b00, 1'b1);
    step("long_a_idle", 2'b00, 1'b0);

    // Single-cycle B pulse gives exactly four cycles of grant
    REQ_B = 1'b1;
    step("pulse_b0", 2'b01, 1'b1);
    REQ_B = 1'b0;
    for (int i = 1; i < 4; i++) step("pulse_b", 2'b01, 1'b1);
    step("pulse_b_gap", 2'b00, 1'b1);
    step("pulse_b_idle", 2'b00, 1'b0);

    // Both requesting from reset: 8-cycle round-robin with single gaps
    reset = 1'b1;
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    step("rr_rst", 2'b00, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step("rr_a1", 2'b10, 1'b1);
    step("rr_gap1", 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) step("rr_b1", 2'b01, 1'b1);
    step("rr_gap2", 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) step("rr_a2", 2'b10, 1'b1);
    step("rr_gap3", 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step("rr_b2", 2'b01, 1'b1);

    // Reset at cnt=2 of GRANT_B: last returns to B so A wins next
    reset = 1'b1;
    step("mid_rst", 2'b00, 1'b0);
    reset = 1'b0;
    step("mid_rel", 2'b10, 1'b1);
    step("mid_a1", 2'b10, 1'b1);

    // Force both at cnt=1 of GRANT_A, then back to arbitration
    MODO = 2'b11;
    step("frc_gap", 2'b00, 1'b1);
    step("frc_11", 2'b11, 1'b1);
    step("frc_11b", 2'b11, 1'b1);
    MODO  = 2'b00;
    REQ_A = 1'b0;
    REQ_B = 1'b1;
    step("unfrc_gap", 2'b00, 1'b1);
    step("unfrc_b", 2'b01, 1'b1);
    REQ_B = 1'b0;
    for (int i = 1; i < 4; i++) step("unfrc_b_hold", 2'b01, 1'b1);
    step("unfrc_b_gap", 2'b00, 1'b1);
    step("unfrc_idle", 2'b00, 1'b0);

    // IDLE to FORCE needs no gap; force change still passes through one
    MODO = 2'b10;
    step("idle_frc_a", 2'b10, 1'b1);
    MODO = 2'b01;
    step("frc_chg_gap", 2'b00, 1'b1);
    step("frc_b", 2'b01, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
